hazard_ctrl_pipe: RTL and testbench

HAZARD_CTRL_PIPE -- requirements
Module: hazard_ctrl_pipe

---
 rtl/hazard_ctrl_pipe.sv | 156 +++++++++++++++
 tb/tb_hazard_ctrl_pipe.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_pipe.sv
// Load-use hazard detection, branch flush and EX/MEM/WB control-bundle pipeline
// for a classic five-stage pipeline, with a saturating stall performance counter.
module hazard_ctrl_pipe #(
  parameter int CTRL_N       = 9,
  parameter int N_REG_ADDR   = 5,
  parameter int STALL_CYCLES = 1,
  parameter int N_PERF       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CTRL_N-1:0]     ctrl_id,
  input  logic                  id_mem_read,
  input  logic                  id_reg_write,
  input  logic [N_REG_ADDR-1:0] id_dest,
  input  logic [N_REG_ADDR-1:0] id_rs,
  input  logic [N_REG_ADDR-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  branch_taken,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  ctrl_sel,
  output logic [CTRL_N-1:0]     ctrl_ex,
  output logic [CTRL_N-1:0]     ctrl_mem,
  output logic [CTRL_N-1:0]     ctrl_wb,
  output logic [N_REG_ADDR-1:0] ex_dest,
  output logic [N_REG_ADDR-1:0] mem_dest,
  output logic [N_REG_ADDR-1:0] wb_dest,
  output logic                  wb_reg_write,
  output logic [N_PERF-1:0]     stall_count
);

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [1:0] REM_INIT = (STALL_CYCLES > 1) ? 2'(STALL_CYCLES - 2) : 2'd0;

  state_t                state_q, state_d;
  logic [1:0]            rem_q, rem_d;
  logic [N_PERF-1:0]     stall_count_q, stall_count_d;

  // mem_read is only consulted while the load sits in EX, so it is not kept further down
  logic [CTRL_N-1:0]     ctrl_ex_q, ctrl_ex_d;
  logic                  ex_mem_read_q, ex_mem_read_d;
  logic                  ex_reg_write_q, ex_reg_write_d;
  logic [N_REG_ADDR-1:0] ex_dest_q, ex_dest_d;

  logic [CTRL_N-1:0]     ctrl_mem_q, ctrl_mem_d;
  logic                  mem_reg_write_q, mem_reg_write_d;
  logic [N_REG_ADDR-1:0] mem_dest_q, mem_dest_d;

  logic [CTRL_N-1:0]     ctrl_wb_q, ctrl_wb_d;
  logic                  wb_reg_write_q, wb_reg_write_d;
  logic [N_REG_ADDR-1:0] wb_dest_q, wb_dest_d;

  logic hz;
  logic bubble;

  always_comb begin
    hz = (state_q == RUN) && ex_mem_read_q && (ex_dest_q != '0) &&
         ((ex_dest_q == id_rs) || (id_uses_rt && (ex_dest_q == id_rt)));
    bubble = !branch_taken && (hz || (state_q == STALL));

    // While reset is held the datapath controls read as free-running
    pc_write   = !(reset && bubble);
    ifid_write = !(reset && bubble);
    ifid_flush = reset && branch_taken;
    ctrl_sel   = reset && (bubble || branch_taken);
  end

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    stall_count_d = stall_count_q;

    ctrl_wb_d      = ctrl_mem_q;
    wb_reg_write_d = mem_reg_write_q;
    wb_dest_d      = mem_dest_q;

    ctrl_mem_d      = ctrl_ex_q;
    mem_reg_write_d = ex_reg_write_q;
    mem_dest_d      = ex_dest_q;

    ctrl_ex_d      = ctrl_id;
    ex_mem_read_d  = id_mem_read;
    ex_reg_write_d = id_reg_write;
    ex_dest_d      = id_dest;

    if (branch_taken) begin
      ctrl_mem_d      = '0;
      mem_reg_write_d = 1'b0;
      mem_dest_d      = '0;
    end

    if (branch_taken || bubble) begin
      ctrl_ex_d      = '0;
      ex_mem_read_d  = 1'b0;
      ex_reg_write_d = 1'b0;
      ex_dest_d      = '0;
    end

    if (branch_taken) begin
      state_d = RUN;
      rem_d   = 2'd0;
    end else if (state_q == STALL) begin
      if (rem_q == 2'd0) state_d = RUN;
      else               rem_d   = rem_q - 2'd1;
    end else if (hz && (STALL_CYCLES > 1)) begin
      state_d = STALL;
      rem_d   = REM_INIT;
    end

    if (bubble && (stall_count_q != '1)) stall_count_d = stall_count_q + N_PERF'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= RUN;
      rem_q           <= 2'd0;
      stall_count_q   <= '0;
      ctrl_ex_q       <= '0;
      ex_mem_read_q   <= 1'b0;
      ex_reg_write_q  <= 1'b0;
      ex_dest_q       <= '0;
      ctrl_mem_q      <= '0;
      mem_reg_write_q <= 1'b0;
      mem_dest_q      <= '0;
      ctrl_wb_q       <= '0;
      wb_reg_write_q  <= 1'b0;
      wb_dest_q       <= '0;
    end else begin
      state_q         <= state_d;
      rem_q           <= rem_d;
      stall_count_q   <= stall_count_d;
      ctrl_ex_q       <= ctrl_ex_d;
      ex_mem_read_q   <= ex_mem_read_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_dest_q       <= ex_dest_d;
      ctrl_mem_q      <= ctrl_mem_d;
      mem_reg_write_q <= mem_reg_write_d;
      mem_dest_q      <= mem_dest_d;
      ctrl_wb_q       <= ctrl_wb_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_dest_q       <= wb_dest_d;
    end
  end

  assign ctrl_ex      = ctrl_ex_q;
  assign ctrl_mem     = ctrl_mem_q;
  assign ctrl_wb      = ctrl_wb_q;
  assign ex_dest      = ex_dest_q;
  assign mem_dest     = mem_dest_q;
  assign wb_dest      = wb_dest_q;
  assign wb_reg_write = wb_reg_write_q;
  assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Drives three hazard_ctrl_pipe instances (1-cycle stall, 3-cycle stall, 4-bit counter)
// with shared inputs and compares each against a bubbles-remaining pipeline model.
module tb_hazard_ctrl_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] ctrl_id;
  logic       id_mem_read, id_reg_write, id_uses_rt, branch_taken;
  logic [4:0] id_dest, id_rs, id_rt;

  logic [2:0]  o_pcw, o_ifw, o_fl, o_sel, o_wbrw;
  logic [8:0]  o_cex [3];
  logic [8:0]  o_cmem [3];
  logic [8:0]  o_cwb [3];
  logic [4:0]  o_dex [3];
  logic [4:0]  o_dmem [3];
  logic [4:0]  o_dwb [3];
  logic [15:0] cnt0, cnt1;
  logic [3:0]  cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: stage 0 = EX, 1 = MEM, 2 = WB; m_bub = bubbles still owed after this cycle
  logic [8:0] m_ctrl [3][3];
  logic       m_mr   [3][3];
  logic       m_rw   [3][3];
  logic [4:0] m_dst  [3][3];
  int         m_bub  [3];
  int         m_cnt  [3];
  int         sc_of   [3] = '{1, 3, 1};
  int         cmax_of [3] = '{65535, 65535, 15};

  always #5 clk = ~clk;

  hazard_ctrl_pipe #(.STALL_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .ctrl_id(ctrl_id), .id_mem_read(id_mem_read),
    .id_reg_write(id_reg_write), .id_dest(id_dest), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .branch_taken(branch_taken),
    .pc_write(o_pcw[0]), .ifid_write(o_ifw[0]), .ifid_flush(o_fl[0]), .ctrl_sel(o_sel[0]),
    .ctrl_ex(o_cex[0]), .ctrl_mem(o_cmem[0]), .ctrl_wb(o_cwb[0]),
    .ex_dest(o_dex[0]), .mem_dest(o_dmem[0]), .wb_dest(o_dwb[0]),
    .wb_reg_write(o_wbrw[0]), .stall_count(cnt0));

  hazard_ctrl_pipe #(.STALL_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .ctrl_id(ctrl_id), .id_mem_read(id_mem_read),
    .id_reg_write(id_reg_write), .id_dest(id_dest), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .branch_taken(branch_taken),
    .pc_write(o_pcw[1]), .ifid_write(o_ifw[1]), .ifid_flush(o_fl[1]), .ctrl_sel(o_sel[1]),
    .ctrl_ex(o_cex[1]), .ctrl_mem(o_cmem[1]), .ctrl_wb(o_cwb[1]),
    .ex_dest(o_dex[1]), .mem_dest(o_dmem[1]), .wb_dest(o_dwb[1]),
    .wb_reg_write(o_wbrw[1]), .stall_count(cnt1));

  hazard_ctrl_pipe #(.STALL_CYCLES(1), .N_PERF(4)) dutp4 (
    .clk(clk), .reset(reset), .ctrl_id(ctrl_id), .id_mem_read(id_mem_read),
    .id_reg_write(id_reg_write), .id_dest(id_dest), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .branch_taken(branch_taken),
    .pc_write(o_pcw[2]), .ifid_write(o_ifw[2]), .ifid_flush(o_fl[2]), .ctrl_sel(o_sel[2]),
    .ctrl_ex(o_cex[2]), .ctrl_mem(o_cmem[2]), .ctrl_wb(o_cwb[2]),
    .ex_dest(o_dex[2]), .mem_dest(o_dmem[2]), .wb_dest(o_dwb[2]),
    .wb_reg_write(o_wbrw[2]), .stall_count(cnt2));

  function automatic logic [15:0] dut_cnt(int i);
    case (i)
      0:       return cnt0;
      1:       return cnt1;
      default: return {12'd0, cnt2};
    endcase
  endfunction

  function automatic logic m_stall(int i);
    logic hz;
    hz = m_mr[i][0] && (m_dst[i][0] != 5'd0) &&
         ((m_dst[i][0] == id_rs) || (id_uses_rt && (m_dst[i][0] == id_rt)));
    return reset && !branch_taken && ((m_bub[i] > 0) || hz);
  endfunction

  task automatic set_id(input logic [8:0] c, input logic mr, input logic rw, input logic [4:0] d,
                        input logic [4:0] rs, input logic [4:0] rt, input logic ur);
    ctrl_id = c; id_mem_read = mr; id_reg_write = rw; id_dest = d;
    id_rs = rs; id_rt = rt; id_uses_rt = ur;
  endtask

  task automatic tick();
    logic st [3];
    logic br;
    br = reset && branch_taken;
    for (int i = 0; i < 3; i++) st[i] = m_stall(i);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!reset) begin
        for (int s = 0; s < 3; s++) begin
          m_ctrl[i][s] = '0; m_mr[i][s] = 0; m_rw[i][s] = 0; m_dst[i][s] = '0;
        end
        m_bub[i] = 0;
        m_cnt[i] = 0;
      end else begin
        m_ctrl[i][2] = m_ctrl[i][1]; m_mr[i][2] = m_mr[i][1];
        m_rw[i][2]   = m_rw[i][1];   m_dst[i][2] = m_dst[i][1];
        if (br) begin
          m_ctrl[i][1] = '0; m_mr[i][1] = 0; m_rw[i][1] = 0; m_dst[i][1] = '0;
          m_bub[i] = 0;
        end else begin
          m_ctrl[i][1] = m_ctrl[i][0]; m_mr[i][1] = m_mr[i][0];
          m_rw[i][1]   = m_rw[i][0];   m_dst[i][1] = m_dst[i][0];
        end
        if (br || st[i]) begin
          m_ctrl[i][0] = '0; m_mr[i][0] = 0; m_rw[i][0] = 0; m_dst[i][0] = '0;
        end else begin
          m_ctrl[i][0] = ctrl_id; m_mr[i][0] = id_mem_read;
          m_rw[i][0]   = id_reg_write; m_dst[i][0] = id_dest;
        end
        if (!br && st[i]) begin
          m_bub[i] = (m_bub[i] > 0) ? m_bub[i] - 1 : sc_of[i] - 1;
          if (m_cnt[i] < cmax_of[i]) m_cnt[i]++;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; branch_taken = 1'b0;
    set_id(9'h0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; branch_taken = 1'b1;
    set_id(9'h1FF, 1, 1, 5'd8, 5'd8, 5'd8, 1);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({o_pcw[i], o_ifw[i], o_fl[i], o_sel[i]} !== 4'b1100) begin
        n_fail++;
        $display("[TB] FAIL reset_comb[%0d] got pcw/ifw/flush/sel=%b%b%b%b exp 1100",
                 i, o_pcw[i], o_ifw[i], o_fl[i], o_sel[i]);
      end
    end
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({o_cex[i], o_cmem[i], o_cwb[i], o_dex[i], o_dmem[i], o_dwb[i], o_wbrw[i], dut_cnt(i)} !== '0) begin
        n_fail++;
        $display("[TB] FAIL reset_state[%0d] got ex=%h mem=%h wb=%h cnt=%0d exp all zero",
                 i, o_cex[i], o_cmem[i], o_cwb[i], dut_cnt(i));
      end
    end
    branch_taken = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_load_use();
    logic [1:0] exp_sel;
    do_reset();
    set_id(9'h055, 1, 1, 5'd8, 5'd1, 5'd2, 1);
    tick();
    set_id(9'h0A3, 0, 1, 5'd9, 5'd8, 5'd3, 1);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (o_pcw[i] !== 1'b0 || o_sel[i] !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL load_use_detect[%0d] got pcw=%b sel=%b exp 0/1", i, o_pcw[i], o_sel[i]);
      end
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (o_cex[i] !== 9'h0 || o_cmem[i] !== 9'h055 || dut_cnt(i) !== 16'd1) begin
        n_fail++;
        $display("[TB] FAIL load_use_bubble[%0d] got ex=%h mem=%h cnt=%0d exp 000/055/1",
                 i, o_cex[i], o_cmem[i], dut_cnt(i));
      end
    end
    // add held in ID: the 1-cycle instance moves on, the 3-cycle one keeps bubbling twice more
    for (int c = 0; c < 3; c++) begin
      #1;
      exp_sel = (c < 2) ? 2'b10 : 2'b00;
      n_checks++;
      if ({o_sel[1], o_sel[0]} !== exp_sel || o_pcw[1] !== ~exp_sel[1]) begin
        n_fail++;
        $display("[TB] FAIL load_use_hold_c%0d got sel3/sel1=%b%b pcw3=%b exp %b", c, o_sel[1], o_sel[0], o_pcw[1], exp_sel);
      end
      tick();
    end
    n_checks++;
    if (o_cex[1] !== 9'h0A3 || cnt1 !== 16'd3 || cnt0 !== 16'd1) begin
      n_fail++;
      $display("[TB] FAIL load_use_release got ex3=%h cnt3=%0d cnt1=%0d exp 0a3/3/1", o_cex[1], cnt1, cnt0);
    end
  endtask

  task automatic test_no_hazard();
    do_reset();
    set_id(9'h011, 1, 1, 5'd0, 5'd4, 5'd5, 1);
    tick();
    set_id(9'h022, 0, 1, 5'd6, 5'd0, 5'd0, 1);
    #1;
    n_checks++;
    if (o_sel !== 3'b000 || o_pcw !== 3'b111) begin
      n_fail++;
      $display("[TB] FAIL no_hazard_r0 got sel=%b pcw=%b exp 000/111", o_sel, o_pcw);
    end
    tick();
    set_id(9'h033, 1, 1, 5'd8, 5'd4, 5'd5, 1);
    tick();
    set_id(9'h044, 0, 1, 5'd7, 5'd1, 5'd8, 0);
    #1;
    n_checks++;
    if (o_sel !== 3'b000 || o_ifw !== 3'b111) begin
      n_fail++;
      $display("[TB] FAIL no_hazard_rt_unused got sel=%b ifw=%b exp 000/111", o_sel, o_ifw);
    end
    tick();
    n_checks++;
    if (cnt0 !== 16'd0 || cnt1 !== 16'd0 || cnt2 !== 4'd0 || o_cex[0] !== 9'h044) begin
      n_fail++;
      $display("[TB] FAIL no_hazard_count got cnt=%0d/%0d/%0d ex=%h exp 0/0/0/044", cnt0, cnt1, cnt2, o_cex[0]);
    end
  endtask

  task automatic test_flush_in_stall();
    do_reset();
    set_id(9'h055, 1, 1, 5'd8, 5'd1, 5'd2, 1);
    tick();
    set_id(9'h0A3, 0, 1, 5'd9, 5'd8, 5'd3, 1);
    tick();
    branch_taken = 1'b1;
    #1;
    n_checks++;
    if (o_fl[1] !== 1'b1 || o_pcw[1] !== 1'b1 || o_ifw[1] !== 1'b1 || o_sel[1] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL flush_comb got flush=%b pcw=%b ifw=%b sel=%b exp 1111", o_fl[1], o_pcw[1], o_ifw[1], o_sel[1]);
    end
    tick();
    branch_taken = 1'b0;
    n_checks++;
    if (o_cex[1] !== 9'h0 || o_cmem[1] !== 9'h0 || o_cwb[1] !== 9'h055 || cnt1 !== 16'd1) begin
      n_fail++;
      $display("[TB] FAIL flush_state got ex=%h mem=%h wb=%h cnt=%0d exp 000/000/055/1", o_cex[1], o_cmem[1], o_cwb[1], cnt1);
    end
    #1;
    n_checks++;
    if (o_pcw[1] !== 1'b1 || o_sel[1] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL flush_back_to_run got pcw=%b sel=%b exp 1/0", o_pcw[1], o_sel[1]);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      set_id(9'h055, 1, 1, 5'd8, 5'd1, 5'd2, 1);
      tick();
      set_id(9'h0A3, 0, 1, 5'd9, 5'd8, 5'd3, 1);
      tick();
      set_id(9'h000, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      tick(); tick(); tick();
      n_checks++;
      if (cnt2 !== 4'((k + 1 > 15) ? 15 : k + 1)) begin
        n_fail++;
        $display("[TB] FAIL saturation_k%0d got cnt=%0d exp %0d", k, cnt2, (k + 1 > 15) ? 15 : k + 1);
      end
    end
    n_checks++;
    if (cnt0 !== 16'd20 || cnt1 !== 16'd60) begin
      n_fail++;
      $display("[TB] FAIL saturation_wide got cnt1=%0d cnt3=%0d exp 20/60", cnt0, cnt1);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_id(9'h1AB, 0, 1, 5'd3, 5'd1, 5'd2, 1);
    tick();
    set_id(9'h055, 1, 1, 5'd8, 5'd1, 5'd2, 1);
    tick();
    set_id(9'h0A3, 0, 1, 5'd9, 5'd8, 5'd3, 1);
    tick();
    #1;
    n_checks++;
    if (o_cwb[1] !== 9'h1AB || o_sel[1] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mid_stall_setup got wb=%h sel=%b exp 1ab/1", o_cwb[1], o_sel[1]);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (o_cex[1] !== 9'h0 || o_cmem[1] !== 9'h0 || o_cwb[1] !== 9'h0 || cnt1 !== 16'd0 || o_pcw[1] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mid_stall_reset got ex=%h mem=%h wb=%h cnt=%0d pcw=%b exp 0/0/0/0/1",
               o_cex[1], o_cmem[1], o_cwb[1], cnt1, o_pcw[1]);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (o_sel[1] !== 1'b0 || o_pcw[1] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mid_stall_release got sel=%b pcw=%b exp 0/1", o_sel[1], o_pcw[1]);
    end
    tick();
    n_checks++;
    if (o_cex[1] !== 9'h0A3) begin
      n_fail++;
      $display("[TB] FAIL mid_stall_advance got ex=%h exp 0a3", o_cex[1]);
    end
  endtask

  task automatic test_random();
    logic st;
    for (int c = 0; c < 400; c++) begin
      reset        = ($urandom_range(0, 39) != 0);
      branch_taken = ($urandom_range(0, 7) == 0);
      set_id(9'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom));
      #1;
      for (int i = 0; i < 3; i++) begin
        st = m_stall(i);
        n_checks++;
        if ({o_pcw[i], o_ifw[i], o_fl[i], o_sel[i]} !==
            {~st, ~st, reset & branch_taken, st | (reset & branch_taken)}) begin
          n_fail++;
          $display("[TB] FAIL random_comb[%0d] c%0d got pcw/ifw/flush/sel=%b%b%b%b exp %b%b%b%b", i, c,
                   o_pcw[i], o_ifw[i], o_fl[i], o_sel[i], ~st, ~st, reset & branch_taken, st | (reset & branch_taken));
        end
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if ({o_cex[i], o_cmem[i], o_cwb[i]} !== {m_ctrl[i][0], m_ctrl[i][1], m_ctrl[i][2]}) begin
          n_fail++;
          $display("[TB] FAIL random_ctrl[%0d] c%0d got %h/%h/%h exp %h/%h/%h", i, c,
                   o_cex[i], o_cmem[i], o_cwb[i], m_ctrl[i][0], m_ctrl[i][1], m_ctrl[i][2]);
        end
        n_checks++;
        if ({o_dex[i], o_dmem[i], o_dwb[i], o_wbrw[i]} !== {m_dst[i][0], m_dst[i][1], m_dst[i][2], m_rw[i][2]}) begin
          n_fail++;
          $display("[TB] FAIL random_dest[%0d] c%0d got %0d/%0d/%0d rw=%b exp %0d/%0d/%0d rw=%b", i, c,
                   o_dex[i], o_dmem[i], o_dwb[i], o_wbrw[i], m_dst[i][0], m_dst[i][1], m_dst[i][2], m_rw[i][2]);
        end
        n_checks++;
        if (dut_cnt(i) !== 16'(m_cnt[i])) begin
          n_fail++;
          $display("[TB] FAIL random_count[%0d] c%0d got %0d exp %0d", i, c, dut_cnt(i), m_cnt[i]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      for (int s = 0; s < 3; s++) begin
        m_ctrl[i][s] = '0; m_mr[i][s] = 0; m_rw[i][s] = 0; m_dst[i][s] = '0;
      end
      m_bub[i] = 0;
      m_cnt[i] = 0;
    end
    test_reset();
    test_load_use();
    test_no_hazard();
    test_flush_in_stall();
    test_saturation();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
